// File: rtl/datapath_controller.sv
// Fetch/decode/execute sequencer for the processor register unit.
// Moore FSM: every datapath strobe is decoded from the current state and,
// in execute/operand states, from the opcode held in IR.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            one-cycle pulse; leaves IDLE or HALT
//   ir_opcode        opcode currently held in IR
//   z_flag           1 when AC == 0
//   LDIR             IR <= DR
//   PC_INC..RC_INC   register increment strobes
//   read             DR <= RAM[AR]
//   mem_write        RAM[AR] <= DR
//   C_bus_ctrl_sig   C-bus write enables (RD,PC,RA,RB,RC,R1,R2,R3,DR,AR,AC)
//   select           mux source for the ALU operand
//   alu_op           C-bus source: PASS, ADD, SUB, ZERO
//   busy, halted     status
module datapath_controller #(
    parameter int unsigned INSTRUCTION_LEN = 6,
    parameter int unsigned C_BUS_SIG_LEN   = 11,
    parameter int unsigned MUX_SEL_SIG     = 4,
    parameter int unsigned ALU_OP_LEN      = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [INSTRUCTION_LEN-1:0] ir_opcode,
    input  logic                       z_flag,
    output logic                       LDIR,
    output logic                       PC_INC,
    output logic                       AC_INC,
    output logic                       RA_INC,
    output logic                       RB_INC,
    output logic                       RC_INC,
    output logic                       read,
    output logic                       mem_write,
    output logic [C_BUS_SIG_LEN-1:0]   C_bus_ctrl_sig,
    output logic [MUX_SEL_SIG-1:0]     select,
    output logic [ALU_OP_LEN-1:0]      alu_op,
    output logic                       busy,
    output logic                       halted
);

    // C-bus write-enable bit positions
    localparam int unsigned BitRd = 10;
    localparam int unsigned BitPc = 9;
    localparam int unsigned BitRa = 8;
    localparam int unsigned BitRb = 7;
    localparam int unsigned BitRc = 6;
    localparam int unsigned BitR1 = 5;
    localparam int unsigned BitR2 = 4;
    localparam int unsigned BitR3 = 3;
    localparam int unsigned BitDr = 2;
    localparam int unsigned BitAr = 1;
    localparam int unsigned BitAc = 0;

    localparam logic [3:0] SelDr = 4'd0;
    localparam logic [3:0] SelAc = 4'd8;
    localparam logic [3:0] SelPc = 4'd9;

    localparam logic [1:0] AluPass = 2'd0;
    localparam logic [1:0] AluAdd  = 2'd1;
    localparam logic [1:0] AluZero = 2'd3;

    typedef enum logic [3:0] {
        StIdle, StInit, StF1, StF2, StF3, StDec, StEx, StOa1,
        StOa2, StOa3, StLd1, StLd2, StSt1, StSt2, StJp, StHalt
    } state_e;

    state_e state_q, state_d;
    logic   taken_q, taken_d;

    logic [1:0] op_class;
    logic [3:0] op_idx;
    assign op_class = ir_opcode[INSTRUCTION_LEN-1 -: 2];
    assign op_idx   = ir_opcode[3:0];

    // Opcode classification used by DEC and the operand states
    logic dec_end, dec_ex, dec_oa, dec_jump, dec_taken;
    always_comb begin
        dec_end   = 1'b0;
        dec_ex    = 1'b0;
        dec_oa    = 1'b0;
        dec_jump  = 1'b0;
        dec_taken = 1'b0;
        case (op_class)
            2'b00: begin
                case (op_idx)
                    4'h1, 4'h2: dec_oa = 1'b1;
                    4'h3: begin
                        dec_oa    = 1'b1;
                        dec_jump  = 1'b1;
                        dec_taken = 1'b1;
                    end
                    4'h4: begin
                        dec_oa    = 1'b1;
                        dec_jump  = 1'b1;
                        dec_taken = z_flag;
                    end
                    4'h5: begin
                        dec_oa    = 1'b1;
                        dec_jump  = 1'b1;
                        dec_taken = ~z_flag;
                    end
                    4'h6, 4'h7, 4'h8, 4'h9, 4'hA: dec_ex = 1'b1;
                    4'hF: dec_end = 1'b1;
                    default: ;
                endcase
            end
            // MVR has no destination for idx 8 (AC itself)
            2'b01:   dec_ex = (op_idx <= 4'd9) && (op_idx != 4'd8);
            default: dec_ex = (op_idx <= 4'd9);
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StInit;
            StInit:  state_d = StF1;
            StF1:    state_d = StF2;
            StF2:    state_d = StF3;
            StF3:    state_d = StDec;
            StDec: begin
                taken_d = dec_taken;
                if (dec_end)     state_d = StHalt;
                else if (dec_ex) state_d = StEx;
                else if (dec_oa) state_d = StOa1;
                else             state_d = StF1;
            end
            StEx:    state_d = StF1;
            StOa1:   state_d = StOa2;
            StOa2: begin
                if (dec_jump) state_d = taken_q ? StJp : StF1;
                else          state_d = StOa3;
            end
            StOa3:   state_d = (op_idx == 4'h1) ? StLd1 : StSt1;
            StLd1:   state_d = StLd2;
            StLd2:   state_d = StF1;
            StSt1:   state_d = StSt2;
            StSt2:   state_d = StF1;
            StJp:    state_d = StF1;
            StHalt:  if (start) state_d = StInit;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
        end
    end

    // Moore output decode
    always_comb begin
        LDIR           = 1'b0;
        PC_INC         = 1'b0;
        AC_INC         = 1'b0;
        RA_INC         = 1'b0;
        RB_INC         = 1'b0;
        RC_INC         = 1'b0;
        read           = 1'b0;
        mem_write      = 1'b0;
        C_bus_ctrl_sig = '0;
        select         = '0;
        alu_op         = '0;
        busy           = (state_q != StIdle) && (state_q != StHalt);
        halted         = (state_q == StHalt);
        unique case (state_q)
            StInit: begin
                alu_op                = ALU_OP_LEN'(AluZero);
                C_bus_ctrl_sig[BitPc] = 1'b1;
                C_bus_ctrl_sig[BitAc] = 1'b1;
            end
            StF1, StOa1: begin
                select                = MUX_SEL_SIG'(SelPc);
                C_bus_ctrl_sig[BitAr] = 1'b1;
            end
            StF2, StOa2: begin
                read   = 1'b1;
                PC_INC = 1'b1;
            end
            StF3: LDIR = 1'b1;
            StEx: begin
                case (op_class)
                    2'b00: begin
                        case (op_idx)
                            4'h6: AC_INC = 1'b1;
                            4'h7: begin
                                alu_op                = ALU_OP_LEN'(AluZero);
                                C_bus_ctrl_sig[BitAc] = 1'b1;
                            end
                            4'h8: RA_INC = 1'b1;
                            4'h9: RB_INC = 1'b1;
                            4'hA: RC_INC = 1'b1;
                            default: ;
                        endcase
                    end
                    2'b01: begin
                        select = MUX_SEL_SIG'(SelAc);
                        case (op_idx)
                            4'd0: C_bus_ctrl_sig[BitDr] = 1'b1;
                            4'd1: C_bus_ctrl_sig[BitR1] = 1'b1;
                            4'd2: C_bus_ctrl_sig[BitR2] = 1'b1;
                            4'd3: C_bus_ctrl_sig[BitR3] = 1'b1;
                            4'd4: C_bus_ctrl_sig[BitRa] = 1'b1;
                            4'd5: C_bus_ctrl_sig[BitRb] = 1'b1;
                            4'd6: C_bus_ctrl_sig[BitRc] = 1'b1;
                            4'd7: C_bus_ctrl_sig[BitRd] = 1'b1;
                            4'd9: C_bus_ctrl_sig[BitPc] = 1'b1;
                            default: ;
                        endcase
                    end
                    2'b10: begin
                        select                = MUX_SEL_SIG'(op_idx);
                        C_bus_ctrl_sig[BitAc] = 1'b1;
                    end
                    default: begin
                        select                = MUX_SEL_SIG'(op_idx);
                        alu_op                = ALU_OP_LEN'(AluAdd);
                        C_bus_ctrl_sig[BitAc] = 1'b1;
                    end
                endcase
            end
            StOa3: begin
                select                = MUX_SEL_SIG'(SelDr);
                C_bus_ctrl_sig[BitAr] = 1'b1;
            end
            StLd1: read = 1'b1;
            StLd2: begin
                select                = MUX_SEL_SIG'(SelDr);
                alu_op                = ALU_OP_LEN'(AluPass);
                C_bus_ctrl_sig[BitAc] = 1'b1;
            end
            StSt1: begin
                select                = MUX_SEL_SIG'(SelAc);
                C_bus_ctrl_sig[BitDr] = 1'b1;
            end
            StSt2: mem_write = 1'b1;
            StJp: begin
                select                = MUX_SEL_SIG'(SelDr);
                C_bus_ctrl_sig[BitPc] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
